dadda_mul_pipe: RTL and testbench

Parametrised, pipelined Dadda-tree unsigned multiplier with a run-time selectable approximate low-column region and a valid/ready stream interface. It succeeds the fixed 6-bit combinational Dadda multipliers in the approximate-multiplier library. Reduction and the final carry-propagate add are split across registered stages so the block closes timing at larger widths. It is the multiplier core used by the accuracy/energy characterisation harness and by downstream MAC datapaths.

---
 rtl/dadda_mul_pipe.sv | 183 ++++++++++++++++++
 tb/tb_dadda_mul_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_pipe.sv
// dadda_mul_pipe: 3-stage Dadda-tree unsigned multiplier with per-beat approximate low columns
module dadda_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_approx,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_prod,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_approx
);
  localparam int PW = 2*WIDTH;
  localparam int DSEQ [8] = '{2, 3, 4, 6, 9, 13, 19, 28};

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 ap1_q, ap1_d, ap2_q, ap2_d, ap3_q, ap3_d;
  logic [TAG_WIDTH-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [PW-1:0]        r0_q, r0_d, r1_q, r1_d, prod_q, prod_d;
  logic [PW-1:0]        row0, row1;
  logic                 adv1, adv2, adv3;

  // each stage moves when the slot below it is empty or draining
  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign in_ready   = adv1;
  assign out_valid  = v3_q;
  assign out_prod   = prod_q;
  assign out_tag    = tag3_q;
  assign out_approx = ap3_q;

  // partial products, approximate OR columns, then Dadda reduction to two rows
  always_comb begin : reduce
    logic [WIDTH-1:0] cur [PW];
    logic [WIDTH-1:0] nxt [PW];
    int               ht  [PW];
    int               nh  [PW];
    logic [WIDTH-1:0] cy, cyn;
    int               ncy, ncyn, p, h, n;
    logic             sm, co;
    sm   = 1'b0;
    co   = 1'b0;
    cy   = '0;
    cyn  = '0;
    ncy  = 0;
    ncyn = 0;
    p    = 0;
    h    = 0;
    n    = 0;
    for (int c = 0; c < PW; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      ht[c]  = 0;
      nh[c]  = 0;
    end
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        cur[i+j][ht[i+j]] = a_q[i] & b_q[j];
        ht[i+j] = ht[i+j] + 1;
      end
    // an approximate column keeps its height but holds only the OR, so it never carries
    for (int c = 0; c < PW; c++)
      if (ap1_q && c < APPROX_COLS) cur[c] = {{(WIDTH-1){1'b0}}, |cur[c]};
    for (int s = 7; s >= 0; s--)
      if (DSEQ[s] < WIDTH) begin
        ncy = 0;
        cy  = '0;
        for (int c = 0; c < PW; c++) begin
          nxt[c] = '0;
          n      = 0;
          p      = 0;
          h      = ht[c] + ncy;
          ncyn   = 0;
          cyn    = '0;
          for (int k = 0; k < WIDTH; k++)
            if (h > DSEQ[s] && ht[c] - p >= 2) begin
              if (h == DSEQ[s] + 1 || ht[c] - p == 2) begin
                sm = cur[c][p] ^ cur[c][p+1];
                co = cur[c][p] & cur[c][p+1];
                p  = p + 2;
                h  = h - 1;
              end else begin
                sm = cur[c][p] ^ cur[c][p+1] ^ cur[c][p+2];
                co = (cur[c][p] & cur[c][p+1]) | (cur[c][p+2] & (cur[c][p] ^ cur[c][p+1]));
                p  = p + 3;
                h  = h - 2;
              end
              nxt[c][n] = sm;
              cyn[ncyn] = co;
              n    = n + 1;
              ncyn = ncyn + 1;
            end
          for (int k = 0; k < WIDTH; k++)
            if (k >= p && k < ht[c]) begin
              nxt[c][n] = cur[c][k];
              n = n + 1;
            end
          for (int k = 0; k < WIDTH; k++)
            if (k < ncy) begin
              nxt[c][n] = cy[k];
              n = n + 1;
            end
          nh[c] = n;
          cy    = cyn;
          ncy   = ncyn;
        end
        for (int c = 0; c < PW; c++) begin
          cur[c] = nxt[c];
          ht[c]  = nh[c];
        end
      end
    for (int c = 0; c < PW; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
  end

  // next state of the three stages; data only loads when a beat moves in
  always_comb begin
    v1_d   = adv1 ? in_valid : v1_q;
    a_d    = (in_valid && adv1) ? in_a : a_q;
    b_d    = (in_valid && adv1) ? in_b : b_q;
    ap1_d  = (in_valid && adv1) ? in_approx : ap1_q;
    tag1_d = (in_valid && adv1) ? in_tag : tag1_q;
    v2_d   = adv2 ? v1_q : v2_q;
    r0_d   = (adv2 && v1_q) ? row0 : r0_q;
    r1_d   = (adv2 && v1_q) ? row1 : r1_q;
    ap2_d  = (adv2 && v1_q) ? ap1_q : ap2_q;
    tag2_d = (adv2 && v1_q) ? tag1_q : tag2_q;
    v3_d   = adv3 ? v2_q : v3_q;
    prod_d = (adv3 && v2_q) ? r0_q + r1_q : prod_q;
    ap3_d  = (adv3 && v2_q) ? ap2_q : ap3_q;
    tag3_d = (adv3 && v2_q) ? tag2_q : tag3_q;
  end

  // pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      ap1_q  <= 1'b0;
      tag1_q <= '0;
      r0_q   <= '0;
      r1_q   <= '0;
      ap2_q  <= 1'b0;
      tag2_q <= '0;
      prod_q <= '0;
      ap3_q  <= 1'b0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ap1_q  <= ap1_d;
      tag1_q <= tag1_d;
      r0_q   <= r0_d;
      r1_q   <= r1_d;
      ap2_q  <= ap2_d;
      tag2_q <= tag2_d;
      prod_q <= prod_d;
      ap3_q  <= ap3_d;
      tag3_q <= tag3_d;
    end
  end
endmodule

// File: tb/tb_dadda_mul_pipe.sv
// tb_dadda_mul_pipe: scoreboard bench for three multiplier configurations driven in lockstep
module tb_dadda_mul_pipe;
  typedef struct {
    logic [31:0] p;
    logic [3:0]  t;
    logic        ap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_approx = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;
  int          rmode = 0;
  logic        rdy0, rdy1, rdy2, v0, v1, v2, ox0, ox1, ox2;
  logic [15:0] p0, p2;
  logic [31:0] p1;
  logic [3:0]  t0, t1, t2;
  exp_t        q [3][$];
  int          errors = 0;
  int          checks = 0;
  logic        hold = 1'b0, saw_full = 1'b0;
  logic [15:0] hp;
  logic [3:0]  hq;
  logic        ha;

  dadda_mul_pipe #(.WIDTH(8), .APPROX_COLS(4), .TAG_WIDTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_approx(in_approx), .in_tag(in_tag), .out_valid(v0), .out_ready(out_ready), .out_prod(p0),
    .out_tag(t0), .out_approx(ox0));
  dadda_mul_pipe #(.WIDTH(16), .APPROX_COLS(0), .TAG_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .in_tag(in_tag), .out_valid(v1), .out_ready(out_ready), .out_prod(p1),
    .out_tag(t1), .out_approx(ox1));
  dadda_mul_pipe #(.WIDTH(8), .APPROX_COLS(15), .TAG_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_approx(in_approx), .in_tag(in_tag), .out_valid(v2), .out_ready(out_ready), .out_prod(p2),
    .out_tag(t2), .out_approx(ox2));

  always #5 clk = ~clk;

  // product from the column rule: exact weights at or above K, one OR bit per column below K
  function automatic logic [31:0] model(input logic [15:0] a, b, input logic ap, input int w, k);
    logic [31:0] lo;
    longint      hi;
    lo = '0;
    hi = 0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (a[i] && b[j]) begin
          if (ap && i + j < k) lo[i+j] = 1'b1;
          else hi += longint'(1) << (i + j);
        end
    return 32'(hi) + lo;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [31:0] p, input logic [3:0] t, input logic ap);
    exp_t e;
    if (v && out_ready) begin
      checks++;
      if (q[id].size() == 0) begin
        errors++;
        $display("FAIL unexpected_result dut%0d got prod=%0d tag=%0d, expected no result", id, p, t);
      end else begin
        e = q[id].pop_front();
        if (p !== e.p || t !== e.t || ap !== e.ap) begin
          errors++;
          $display("FAIL result dut%0d got prod=%0d tag=%0d approx=%0b expected prod=%0d tag=%0d approx=%0b",
                   id, p, t, ap, e.p, e.t, e.ap);
        end
      end
    end
  endtask

  // out_ready follows the selected mode shortly after each rising edge
  always @(posedge clk) begin
    #2;
    out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : (($urandom % 4) != 0);
  end

  // monitor: pop on every transfer, and check outputs hold while stalled
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, v0, {16'b0, p0}, t0, ox0);
      mon(1, v1, p1, t1, ox1);
      mon(2, v2, {16'b0, p2}, t2, ox2);
      if (hold) begin
        checks++;
        if (!v0 || p0 !== hp || t0 !== hq || ox0 !== ha) begin
          errors++;
          $display("FAIL hold_stable got v=%0b prod=%0d tag=%0d expected v=1 prod=%0d tag=%0d", v0, p0, t0, hp, hq);
        end
      end
      if (v0 && !out_ready && !rdy0) saw_full = 1'b1;
      hold = v0 && !out_ready;
      hp = p0;
      hq = t0;
      ha = ox0;
    end else hold = 1'b0;
  end

  task automatic send(input logic [15:0] a, b, input logic ap, input logic [3:0] t);
    bit acc;
    in_a = a;
    in_b = b;
    in_approx = ap;
    in_tag = t;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = rdy0;
      if (acc) begin
        q[0].push_back('{model(a, b, ap, 8, 4), t, ap});
        q[1].push_back('{model(a, b, ap, 16, 0), t, ap});
        q[2].push_back('{model(a, b, ap, 8, 15), t, ap});
      end
      @(posedge clk);
      #1;
      if (acc) return;
    end
    errors++;
    checks++;
    $display("FAIL send_timeout in_ready got 0 for 200 cycles, expected 1");
  endtask

  task automatic directed(input logic [15:0] a, b, input logic ap, input logic [3:0] t, input logic [31:0] exp);
    send(a, b, ap, t);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_c1_valid", {31'b0, v0}, 0);
    @(negedge clk);
    chk("latency_c2_valid", {31'b0, v0}, 0);
    @(negedge clk);
    chk("latency_c3_valid", {31'b0, v0}, 1);
    chk("directed_prod", {16'b0, p0}, exp);
    chk("directed_tag", {28'b0, t0}, {28'b0, t});
    chk("directed_approx", {31'b0, ox0}, {31'b0, ap});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    rmode = 0;
    in_valid = 1'b0;
    for (int n = 0; n < 100 && (q[0].size() + q[1].size() + q[2].size()) != 0; n++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk(nm, q[i].size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, v0}, 0);
    chk("reset_out_prod", {16'b0, p0}, 0);
    chk("reset_out_tag", {28'b0, t0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'b0, rdy0}, 1);
    @(posedge clk);
    #1;
    directed(16'd255, 16'd255, 1'b0, 4'd5, 32'd65025);
    directed(16'd255, 16'd255, 1'b1, 4'd6, 32'd64991);
    directed(16'd3, 16'd3, 1'b1, 4'd7, 32'd7);
    directed(16'd3, 16'd5, 1'b1, 4'd8, 32'd15);
    drain("directed_drain");
    fork
      begin
        for (int i = 0; i < 10; i++) send(16'($urandom), 16'($urandom), i[0], i[3:0]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        rmode = 1;
        repeat (6) @(posedge clk);
        rmode = 0;
      end
    join
    drain("backpressure_drain");
    chk("backpressure_in_ready_dropped", {31'b0, saw_full}, 1);
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), i[0], 4'(i + 9));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'b0, v0}, 0);
    chk("midreset_out_prod", {16'b0, p0}, 0);
    for (int i = 0; i < 3; i++) q[i].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", {31'b0, rdy0}, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("midreset_no_stale", {31'b0, v0}, 0);
    rmode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom % 4 == 0) begin
        in_valid = 1'b0;
        in_a = 16'($urandom);
        @(posedge clk);
        #1;
      end else send(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
    end
    drain("random_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
